// File: rtl/morse_seq_driver.sv
// -----------------------------------------------------------------------------
// morse_seq_driver
//   Programmable Morse keying engine. Plays up to MAX_SYMS symbols (dot, dash,
//   character gap, word gap) on dataOut, timing everything in units of
//   UNIT_CYCLES clocks. Supports a start/busy/done handshake, abort and
//   continuous repeat with a word gap between passes.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   start      in   begin playback (sampled only when idle)
//   abort      in   stop playback, return to idle next cycle
//   repeat_en  in   loop the pattern (sampled at the end of each pass)
//   pattern    in   2 bits per symbol: 00 dot, 01 dash, 10 char gap, 11 word gap
//   sym_count  in   number of valid symbols, clamped to MAX_SYMS
//   dataOut    out  keyed output, 1 = mark
//   busy       out  high while a pattern is playing (including repeat gaps)
//   done       out  one-cycle pulse at the end of a non-repeating pass
//   sym_idx    out  index of the symbol currently playing
// -----------------------------------------------------------------------------
module morse_seq_driver #(
  parameter int UNIT_CYCLES = 2,
  parameter int MAX_SYMS    = 16,
  parameter int DOT_UNITS   = 1,
  parameter int DASH_UNITS  = 3,
  parameter int GAP_SYM     = 1,
  parameter int GAP_CHAR    = 3,
  parameter int GAP_WORD    = 7,
  localparam int IDX_W      = (MAX_SYMS > 1) ? $clog2(MAX_SYMS) : 1,
  localparam int SC_W       = $clog2(MAX_SYMS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  repeat_en,
  input  logic [2*MAX_SYMS-1:0] pattern,
  input  logic [SC_W-1:0]       sym_count,
  output logic                  dataOut,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      sym_idx
);

  // Phase lengths in cycles. A zero-length phase still occupies one cycle.
  localparam int DOT_RAW  = DOT_UNITS * UNIT_CYCLES;
  localparam int DASH_RAW = DASH_UNITS * UNIT_CYCLES;
  localparam int SPC_RAW  = GAP_SYM * UNIT_CYCLES;
  localparam int CGAP_RAW = (GAP_CHAR - GAP_SYM) * UNIT_CYCLES;
  localparam int WGAP_RAW = (GAP_WORD - GAP_SYM) * UNIT_CYCLES;
  localparam int DOT_N    = (DOT_RAW  > 0) ? DOT_RAW  : 1;
  localparam int DASH_N   = (DASH_RAW > 0) ? DASH_RAW : 1;
  localparam int SPC_N    = (SPC_RAW  > 0) ? SPC_RAW  : 1;
  localparam int CGAP_N   = (CGAP_RAW > 0) ? CGAP_RAW : 1;
  localparam int WGAP_N   = (WGAP_RAW > 0) ? WGAP_RAW : 1;
  localparam int MAX_A    = (DOT_N  > DASH_N) ? DOT_N  : DASH_N;
  localparam int MAX_B    = (CGAP_N > WGAP_N) ? CGAP_N : WGAP_N;
  localparam int MAX_C    = (MAX_A  > MAX_B)  ? MAX_A  : MAX_B;
  localparam int MAX_N    = (MAX_C  > SPC_N)  ? MAX_C  : SPC_N;
  localparam int CNT_W    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  // The counter is loaded with length-1 and the phase ends when it reads 0.
  localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_N - 1);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_N - 1);
  localparam logic [CNT_W-1:0] SPC_LD  = CNT_W'(SPC_N - 1);
  localparam logic [CNT_W-1:0] CGAP_LD = CNT_W'(CGAP_N - 1);
  localparam logic [CNT_W-1:0] WGAP_LD = CNT_W'(WGAP_N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_SPACE = 3'd2,
    S_GAP   = 3'd3,
    S_RGAP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [2*MAX_SYMS-1:0] pat_q, pat_d;
  logic [SC_W-1:0]       num_q, num_d;
  logic                  data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  adv_s;
  logic                  last_sym_s;
  logic                  cnt_zero_s;
  logic [CNT_W-1:0]      cnt_dec_s;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [1:0]            nxt_sym_s;
  logic [SC_W-1:0]       sc_clamp_s;

  // State a symbol starts in: marks for dot/dash, silent gap otherwise.
  function automatic state_t sym_state(input logic [1:0] s);
    case (s)
      2'b00, 2'b01: sym_state = S_MARK;
      default:      sym_state = S_GAP;
    endcase
  endfunction

  // Counter load value for the first phase of a symbol.
  function automatic logic [CNT_W-1:0] sym_load(input logic [1:0] s);
    case (s)
      2'b00:   sym_load = DOT_LD;
      2'b01:   sym_load = DASH_LD;
      2'b10:   sym_load = CGAP_LD;
      default: sym_load = WGAP_LD;
    endcase
  endfunction

  assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});
  assign cnt_dec_s  = cnt_q - CNT_W'(1);
  assign idx_nxt_s  = idx_q + IDX_W'(1);
  assign nxt_sym_s  = pat_q[{idx_nxt_s, 1'b0} +: 2];
  assign last_sym_s = ((SC_W'(idx_q) + SC_W'(1)) >= num_q);
  assign sc_clamp_s = (sym_count > SC_W'(MAX_SYMS)) ? SC_W'(MAX_SYMS) : sym_count;

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    num_d   = num_q;
    done_d  = 1'b0;
    adv_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (sym_count != {SC_W{1'b0}})) begin
          pat_d   = pattern;
          num_d   = sc_clamp_s;
          idx_d   = {IDX_W{1'b0}};
          state_d = sym_state(pattern[1:0]);
          cnt_d   = sym_load(pattern[1:0]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MARK: begin
        if (cnt_zero_s) begin
          state_d = S_SPACE;
          cnt_d   = SPC_LD;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      S_SPACE, S_GAP: begin
        if (cnt_zero_s) begin
          adv_s = 1'b1;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      S_RGAP: begin
        if (cnt_zero_s) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = sym_state(pat_q[1:0]);
          cnt_d   = sym_load(pat_q[1:0]);
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
      end
    endcase

    // End of a symbol: next symbol back-to-back, repeat gap, or finish.
    if (adv_s) begin
      if (!last_sym_s) begin
        idx_d   = idx_nxt_s;
        state_d = sym_state(nxt_sym_s);
        cnt_d   = sym_load(nxt_sym_s);
      end else if (repeat_en) begin
        state_d = S_RGAP;
        cnt_d   = WGAP_LD;
      end else begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        done_d  = 1'b1;
      end
    end else begin
      done_d = 1'b0;
    end

    // Abort wins over completion and suppresses the done pulse.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = {CNT_W{1'b0}};
      idx_d   = {IDX_W{1'b0}};
      done_d  = 1'b0;
    end else begin
      num_d = num_d;
    end

    data_d = (state_d == S_MARK);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      pat_q   <= {(2*MAX_SYMS){1'b0}};
      num_q   <= {SC_W{1'b0}};
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      num_q   <= num_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dataOut = data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sym_idx = idx_q;

endmodule

// File: tb/tb_morse_seq_driver.sv
module tb_morse_seq_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start1, abort, repeat_en;
  logic [31:0] pattern;
  logic [4:0]  sym_count;
  logic        dataOut0, busy0, done0;
  logic [3:0]  sym_idx0;
  logic        dataOut1, busy1, done1;
  logic [3:0]  sym_idx1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic d;
    logic b;
    logic dn;
    int   idx;   // -1 = don't care
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] pat;
    logic [4:0]  cnt;
    int          busy_n;
    int          done_at;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  morse_seq_driver #(.UNIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .repeat_en(repeat_en),
    .pattern(pattern), .sym_count(sym_count),
    .dataOut(dataOut0), .busy(busy0), .done(done0), .sym_idx(sym_idx0)
  );

  morse_seq_driver #(.UNIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .repeat_en(repeat_en),
    .pattern(pattern), .sym_count(sym_count),
    .dataOut(dataOut1), .busy(busy1), .done(done1), .sym_idx(sym_idx1)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push_n(input logic d, input int n, input int idx);
    exp_t e;
    e.d = d; e.b = 1'b1; e.dn = 1'b0; e.idx = idx;
    repeat (n) exp_q.push_back(e);
  endtask

  // Expected per-cycle waveform of one pass with u clocks per unit.
  task automatic push_pass(input logic [31:0] pat, input int cnt, input int u);
    int n;
    logic [1:0] s;
    n = (cnt > 16) ? 16 : cnt;
    for (int i = 0; i < n; i++) begin
      s = pat[2*i +: 2];
      case (s)
        2'b00:   begin push_n(1'b1, u, i);   push_n(1'b0, u, i); end
        2'b01:   begin push_n(1'b1, 3*u, i); push_n(1'b0, u, i); end
        2'b10:   push_n(1'b0, 2*u, i);
        default: push_n(1'b0, 6*u, i);
      endcase
    end
  endtask

  task automatic push_end();
    exp_t e;
    e.d = 1'b0; e.b = 1'b0; e.dn = 1'b1; e.idx = -1;
    exp_q.push_back(e);
    e.dn = 1'b0;
    exp_q.push_back(e);
  endtask

  // Start on cycle 0, then compare each following cycle against the queue.
  task automatic drive_queue(input int sel, input logic [31:0] pat, input logic [4:0] cnt,
                             input int restart_at, output int busy_n, output int done_at);
    exp_t e;
    int   cyc;
    logic d, b, dn;
    int   ix;
    @(negedge clk);
    pattern = pat; sym_count = cnt;
    if (sel == 1) start1 = 1'b1; else start = 1'b1;
    cyc = 0; busy_n = 0; done_at = -1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; start1 = 1'b0;
      e  = exp_q.pop_front();
      d  = (sel == 1) ? dataOut1 : dataOut0;
      b  = (sel == 1) ? busy1    : busy0;
      dn = (sel == 1) ? done1    : done0;
      ix = (sel == 1) ? int'(sym_idx1) : int'(sym_idx0);
      if (b)  busy_n++;
      if (dn && done_at < 0) done_at = cyc;
      check($sformatf("out[d,b,done] cyc%0d", cyc), int'({d, b, dn}), int'({e.d, e.b, e.dn}));
      if (e.idx >= 0) check($sformatf("sym_idx cyc%0d", cyc), ix, e.idx);
      if (cyc == restart_at) begin
        start = 1'b1; pattern = 32'hFFFF_FFFF; sym_count = 5'd1;
      end
    end
  endtask

  task automatic run_seq(input int sel, input logic [31:0] pat, input logic [4:0] cnt,
                         input int u, input int restart_at, output int busy_n, output int done_at);
    push_pass(pat, int'(cnt), u);
    push_end();
    drive_queue(sel, pat, cnt, restart_at, busy_n, done_at);
  endtask

  initial begin
    int bn, da, dcount, bcount;
    logic [31:0] sos;
    sos = 32'h0000_9580;

    tbl[0] = '{"sos",        sos,          5'd11, 56, 57};
    tbl[1] = '{"dot",        32'h0,        5'd1,  4,  5};
    tbl[2] = '{"dash",       32'h1,        5'd1,  8,  9};
    tbl[3] = '{"char_gap",   32'h2,        5'd1,  4,  5};
    tbl[4] = '{"word_gap",   32'h3,        5'd1,  12, 13};
    tbl[5] = '{"clamp16",    32'h0,        5'd31, 64, 65};
    tbl[6] = '{"dash_wg_dot", 32'hD,       5'd3,  24, 25};

    rst = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    pattern = 32'h0; sym_count = 5'd0;
    repeat (3) @(negedge clk);
    check("reset outs dut0", int'({dataOut0, busy0, done0, sym_idx0}), 0);
    check("reset outs dut1", int'({dataOut1, busy1, done1, sym_idx1}), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_seq(0, tbl[i].pat, tbl[i].cnt, 2, -1, bn, da);
      check({tbl[i].nm, " busy cycles"}, bn, tbl[i].busy_n);
      check({tbl[i].nm, " done cycle"}, da, tbl[i].done_at);
    end

    // Single dash at one clock per unit: high 3, low 1, done in cycle 5.
    run_seq(1, 32'h1, 5'd1, 1, -1, bn, da);
    check("u1 dash busy cycles", bn, 4);
    check("u1 dash done cycle", da, 5);

    // Start and pattern changes while busy do not disturb playback.
    run_seq(0, sos, 5'd11, 2, 10, bn, da);
    check("restart ignored busy", bn, 56);
    check("restart ignored done", da, 57);

    // start with zero symbols is ignored.
    for (int i = 0; i < 5; i++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 0});
    drive_queue(0, sos, 5'd0, -1, bn, da);
    check("zero count busy", bn, 0);

    // Repeat: pass, 12-cycle gap, identical pass; then abort at the last
    // cycle of pass 2, which must beat both the repeat and completion.
    repeat_en = 1'b1;
    push_pass(sos, 11, 2);
    for (int i = 0; i < 12; i++) exp_q.push_back('{1'b0, 1'b1, 1'b0, -1});
    push_pass(sos, 11, 2);
    drive_queue(0, sos, 5'd11, -1, bn, da);
    check("repeat busy cycles", bn, 124);
    check("repeat no done", da, -1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; repeat_en = 1'b0;
    check("abort at pass end outs", int'({dataOut0, busy0, done0}), 0);
    check("abort at pass end idx", int'(sym_idx0), 0);

    // Abort during the second dash (symbol 5, cycle 27).
    push_pass(sos, 11, 2);
    while (exp_q.size() > 27) void'(exp_q.pop_back());
    drive_queue(0, sos, 5'd11, -1, bn, da);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort mid dash outs", int'({dataOut0, busy0, done0}), 0);
    check("abort mid dash idx", int'(sym_idx0), 0);
    dcount = 0; bcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0) dcount++;
      if (busy0) bcount++;
    end
    check("abort no done", dcount, 0);
    check("abort stays idle", bcount, 0);
    run_seq(0, sos, 5'd11, 2, -1, bn, da);
    check("after abort busy", bn, 56);
    check("after abort done", da, 57);

    // Reset in the middle of a dash mark.
    push_pass(32'h1, 1, 2);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    drive_queue(0, 32'h1, 5'd1, -1, bn, da);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid mark outs", int'({dataOut0, busy0, done0, sym_idx0}), 0);
    run_seq(0, 32'h1, 5'd1, 2, -1, bn, da);
    check("after rst busy", bn, 8);
    check("after rst done", da, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
